apb_master_scheduler: RTL and testbench

Two-port APB master scheduler in the APB VIP/DUT environment. It accepts read/write commands from two independent requesters, arbitrates round-robin, and drives one APB3 master bus through the SETUP/ACCESS protocol. Slave responses (prdata, pslverr) return to the granted requester. A programmable pready timeout closes hung transfers with an error.

---
 rtl/apb_master_scheduler.sv | 149 ++++++++++++++
 tb/tb_apb_master_scheduler.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_scheduler.sv
// ---------------------------------------------------------------------------
// apb_master_scheduler
//
// Two-requester APB3 master. Commands from port 0 and port 1 are arbitrated
// round-robin and issued on a single APB bus through SETUP and ACCESS. The
// completion (read data and error flag) goes back only to the port that owned
// the transfer. A programmable pready timeout closes a hung ACCESS phase with
// an error response.
//
// Ports
//   pclk, preset_n              clock, async active-low reset
//   reqN_valid/ready            command handshake, port N (ready is
//                               combinational, only in IDLE)
//   reqN_write/addr/wdata       command payload, port N
//   rspN_valid                  one-cycle completion pulse, port N
//   rsp_rdata, rsp_slverr       shared response payload, held until the next
//                               completion
//   busy                        transfer in flight (SETUP or ACCESS)
//   psel, penable, pwrite,
//   paddr, pwdata               APB master outputs
//   prdata, pready, pslverr     APB slave inputs
// ---------------------------------------------------------------------------
module apb_master_scheduler #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  pclk,
   input  logic                  preset_n,
   // port 0
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic                  req0_write,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   // port 1
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic                  req1_write,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   // responses
   output logic                  rsp0_valid,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_slverr,
   output logic                  busy,
   // APB
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [DATA_WIDTH-1:0] pwdata,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pready,
   input  logic                  pslverr
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   // Timeout compare value; a zero TIMEOUT_CYCLES disables the abort path.
   localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

   state_t      state;
   logic        last_grant;   // port granted most recently (resets to 1)
   logic        owner;        // port owning the transfer in flight
   logic [15:0] wait_cnt;     // ACCESS cycles seen with pready low
   logic        grant0;
   logic        grant1;
   logic        idle_ok;
   logic        timeout_hit;

   // Round-robin: on contention the port that did not win last time wins.
   always_comb begin
      grant0 = req0_valid & (~req1_valid | last_grant);
      grant1 = req1_valid & (~req0_valid | ~last_grant);
   end

   // Ready is gated by reset so it reads 0 the moment reset asserts.
   assign idle_ok     = (state == IDLE) & preset_n;
   assign req0_ready  = idle_ok & grant0;
   assign req1_ready  = idle_ok & grant1;

   assign timeout_hit = TO_EN && (wait_cnt == TO_LAST);

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         wait_cnt   <= '0;
         psel       <= 1'b0;
         penable    <= 1'b0;
         busy       <= 1'b0;
         pwrite     <= 1'b0;
         paddr      <= '0;
         pwdata     <= '0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp_rdata  <= '0;
         rsp_slverr <= 1'b0;
      end else begin
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (grant0 | grant1) begin
                  pwrite     <= grant1 ? req1_write : req0_write;
                  paddr      <= grant1 ? req1_addr  : req0_addr;
                  pwdata     <= grant1 ? req1_wdata : req0_wdata;
                  owner      <= grant1;
                  last_grant <= grant1;
                  state      <= SETUP;
                  psel       <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            SETUP: begin
               state    <= ACCESS;
               penable  <= 1'b1;
               wait_cnt <= '0;
            end
            ACCESS: begin
               // pready takes priority over a timeout landing in the same cycle.
               if (pready || timeout_hit) begin
                  state      <= IDLE;
                  psel       <= 1'b0;
                  penable    <= 1'b0;
                  busy       <= 1'b0;
                  rsp_rdata  <= (pready && !pwrite) ? prdata : '0;
                  rsp_slverr <= pready ? pslverr : 1'b1;
                  rsp0_valid <= ~owner;
                  rsp1_valid <= owner;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            default: begin
               state   <= IDLE;
               psel    <= 1'b0;
               penable <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_scheduler.sv
// ---------------------------------------------------------------------------
// tb_apb_master_scheduler
//
// Directed bench for apb_master_scheduler. A transaction-level model tracks
// the transfer in flight (age in cycles since acceptance) and predicts every
// output each cycle; a compare process checks the DUT against it on the
// falling edge. Directed scenarios then pin latencies, grant order, ACCESS
// lengths and response payloads with hand-computed constants.
// ---------------------------------------------------------------------------
module tb_apb_master_scheduler;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic          pclk, preset_n;
   logic          req0_valid, req0_ready, req0_write;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_wdata;
   logic          req1_valid, req1_ready, req1_write;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_wdata;
   logic          rsp0_valid, rsp1_valid, rsp_slverr, busy;
   logic [DW-1:0] rsp_rdata;
   logic          psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata, prdata;
   logic          pready, pslverr;

   apb_master_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .pclk(pclk), .preset_n(preset_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
      .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr), .busy(busy),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   initial begin
      pclk = 1'b0;
      forever #5 pclk = ~pclk;
   end

   typedef struct packed {
      logic          write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } cmd_t;

   cmd_t q0[$];
   cmd_t q1[$];

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- slave behaviour ----------------
   int            slv_waits = 0;   // wait states before pready; -1 = never ready
   logic [DW-1:0] slv_rdata = '0;
   logic          slv_err   = 1'b0;

   initial begin
      int acc_idx;
      acc_idx = 0;
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = '0;
      forever begin
         @(posedge pclk);
         #1;
         if (psel && penable) acc_idx++;
         else acc_idx = 0;
         pready  = (slv_waits >= 0) && (acc_idx == slv_waits + 1);
         prdata  = slv_rdata;
         pslverr = slv_err;
      end
   end

   // ---------------- requester drivers ----------------
   initial begin
      logic a0, a1;
      req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
      req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
      forever begin
         @(posedge pclk);
         a0 = req0_valid && req0_ready;
         a1 = req1_valid && req1_ready;
         #1;
         if (a0 && q0.size() > 0) void'(q0.pop_front());
         if (a1 && q1.size() > 0) void'(q1.pop_front());
         if (q0.size() > 0) begin
            req0_valid = 1'b1; req0_write = q0[0].write;
            req0_addr  = q0[0].addr; req0_wdata = q0[0].wdata;
         end else req0_valid = 1'b0;
         if (q1.size() > 0) begin
            req1_valid = 1'b1; req1_write = q1[0].write;
            req1_addr  = q1[0].addr; req1_wdata = q1[0].wdata;
         end else req1_valid = 1'b0;
      end
   end

   // ---------------- behavioural model ----------------
   // m_age counts cycles since acceptance: 1 = SETUP, k+1 = k-th ACCESS cycle.
   bit            m_busy   = 0;
   int            m_age    = 0;
   int            m_owner  = 0;
   int            m_last   = 1;
   bit            m_pwrite = 0;
   logic [AW-1:0] m_paddr  = '0;
   logic [DW-1:0] m_pwdata = '0;
   logic [DW-1:0] m_rdata  = '0;
   bit            m_err    = 0;
   bit [1:0]      m_rsp    = '0;

   function automatic int winner(input logic v0, input logic v1, input int last);
      if (v0 && v1) return (last == 0) ? 1 : 0;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   task automatic finish_tx(input bit err, input logic [DW-1:0] data);
      m_rsp[m_owner] = 1'b1;
      m_err          = err;
      m_rdata        = data;
      m_busy         = 0;
      m_age          = 0;
   endtask

   initial begin
      int w;
      forever begin
         @(posedge pclk or negedge preset_n);
         if (!preset_n) begin
            m_busy = 0; m_age = 0; m_owner = 0; m_last = 1;
            m_pwrite = 0; m_paddr = '0; m_pwdata = '0;
            m_rdata = '0; m_err = 0; m_rsp = '0;
         end else begin
            m_rsp = '0;
            if (!m_busy) begin
               w = winner(req0_valid, req1_valid, m_last);
               if (w >= 0) begin
                  m_pwrite = (w == 1) ? req1_write : req0_write;
                  m_paddr  = (w == 1) ? req1_addr  : req0_addr;
                  m_pwdata = (w == 1) ? req1_wdata : req0_wdata;
                  m_owner  = w;
                  m_last   = w;
                  m_busy   = 1;
                  m_age    = 1;
               end
            end else if (m_age == 1) begin
               m_age = 2;
            end else if (pready) begin
               finish_tx(pslverr, m_pwrite ? '0 : prdata);
            end else if (TO != 0 && (m_age - 1) == TO) begin
               finish_tx(1'b1, '0);
            end else begin
               m_age++;
            end
         end
      end
   end

   // ---------------- compare + monitor ----------------
   int   cyc = 0;
   int   acc_cyc = 0;
   int   last_rsp_cyc = 0;
   int   last_rsp_port = -1;
   logic [DW-1:0] last_rsp_rdata = '0;
   logic last_rsp_err = 1'b0;
   int   rsp_cnt[2] = '{0, 0};
   int   cur_len = 0;
   int   last_acc_len = 0;
   int   both_ready = 0;
   int   dut_grants[$];

   initial begin
      int w;
      forever begin
         @(negedge pclk);
         cyc++;
         w = (preset_n && !m_busy) ? winner(req0_valid, req1_valid, m_last) : -1;
         chk("cmp_req0_ready", req0_ready, (w == 0));
         chk("cmp_req1_ready", req1_ready, (w == 1));
         chk("cmp_psel",       psel,       m_busy);
         chk("cmp_penable",    penable,    m_busy && m_age >= 2);
         chk("cmp_busy",       busy,       m_busy);
         chk("cmp_pwrite",     pwrite,     m_pwrite);
         chk("cmp_paddr",      paddr,      m_paddr);
         chk("cmp_pwdata",     pwdata,     m_pwdata);
         chk("cmp_rsp0_valid", rsp0_valid, m_rsp[0]);
         chk("cmp_rsp1_valid", rsp1_valid, m_rsp[1]);
         chk("cmp_rsp_rdata",  rsp_rdata,  m_rdata);
         chk("cmp_rsp_slverr", rsp_slverr, m_err);

         if (!preset_n) cur_len = 0;
         else begin
            if (req0_ready && req1_ready) both_ready++;
            if (req0_ready) begin dut_grants.push_back(0); acc_cyc = cyc; end
            if (req1_ready) begin dut_grants.push_back(1); acc_cyc = cyc; end
            if (psel && penable) cur_len++;
            else if (cur_len != 0) begin last_acc_len = cur_len; cur_len = 0; end
            if (rsp0_valid || rsp1_valid) begin
               last_rsp_cyc   = cyc;
               last_rsp_port  = rsp1_valid ? 1 : 0;
               last_rsp_rdata = rsp_rdata;
               last_rsp_err   = rsp_slverr;
               if (rsp0_valid) rsp_cnt[0]++;
               if (rsp1_valid) rsp_cnt[1]++;
            end
         end
      end
   end

   // ---------------- directed scenarios ----------------
   task automatic tick();
      @(negedge pclk);
      #1;
   endtask

   task automatic wait_rsp(input int port, input int budget, input string name);
      int target, k;
      target = rsp_cnt[port] + 1;
      k = 0;
      while (rsp_cnt[port] < target && k < budget) begin tick(); k++; end
      chk(name, rsp_cnt[port], target);
   endtask

   task automatic wait_both(input int c0, input int c1, input int budget, input string name);
      int k;
      k = 0;
      while ((rsp_cnt[0] < c0 || rsp_cnt[1] < c1) && k < budget) begin tick(); k++; end
      chk({name, "_cnt0"}, rsp_cnt[0], c0);
      chk({name, "_cnt1"}, rsp_cnt[1], c1);
   endtask

   initial begin
      int g0, c0, c1, k;
      preset_n = 1'b0;
      tick();
      chk("rst_psel", psel, 0);
      chk("rst_busy", busy, 0);
      chk("rst_paddr", paddr, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      preset_n = 1'b1;
      repeat (2) tick();

      // single zero-wait write on port 0
      slv_waits = 0; slv_err = 0; slv_rdata = 32'hCAFE_0000;
      q0.push_back('{1'b1, 32'h10, 32'hA5A5_0001});
      wait_rsp(0, 20, "t1_rsp");
      chk("t1_latency", last_rsp_cyc - acc_cyc, 3);
      chk("t1_port",    last_rsp_port, 0);
      chk("t1_slverr",  last_rsp_err, 0);
      chk("t1_rdata",   last_rsp_rdata, 0);
      chk("t1_accl",    last_acc_len, 1);
      chk("t1_paddr",   paddr, 32'h10);
      chk("t1_pwdata",  pwdata, 32'hA5A5_0001);

      // read with 3 wait states on port 1
      c0 = rsp_cnt[0];
      slv_waits = 3; slv_rdata = 32'h1234_5678;
      q1.push_back('{1'b0, 32'h24, 32'h0});
      wait_rsp(1, 30, "t2_rsp");
      chk("t2_accl",  last_acc_len, 4);
      chk("t2_rdata", last_rsp_rdata, 32'h1234_5678);
      chk("t2_port",  last_rsp_port, 1);
      chk("t2_no_p0", rsp_cnt[0], c0);

      // contention: 4 commands on each port
      slv_waits = 0;
      g0 = dut_grants.size();
      c0 = rsp_cnt[0]; c1 = rsp_cnt[1];
      for (int i = 0; i < 4; i++) begin
         q0.push_back('{1'b1, 32'h100 + 32'(i * 4), 32'h1000 + 32'(i)});
         q1.push_back('{1'b0, 32'h200 + 32'(i * 4), 32'h0});
      end
      wait_both(c0 + 4, c1 + 4, 100, "t3");
      chk("t3_ngrants", dut_grants.size(), g0 + 8);
      if (dut_grants.size() >= g0 + 8)
         for (int i = 0; i < 8; i++) chk("t3_order", dut_grants[g0 + i], i % 2);
      chk("t3_both_ready", both_ready, 0);

      // timeout: pready never comes
      slv_waits = -1; slv_rdata = 32'hDEAD_BEEF;
      q0.push_back('{1'b0, 32'h30, 32'h0});
      wait_rsp(0, 40, "t4_rsp");
      chk("t4_accl",   last_acc_len, 16);
      chk("t4_slverr", last_rsp_err, 1);
      chk("t4_rdata",  last_rsp_rdata, 0);
      chk("t4_idle",   busy, 0);

      // pready lands in the 16th ACCESS cycle: normal completion
      slv_waits = 15;
      q0.push_back('{1'b0, 32'h34, 32'h0});
      wait_rsp(0, 40, "t5_rsp");
      chk("t5_accl",   last_acc_len, 16);
      chk("t5_slverr", last_rsp_err, 0);
      chk("t5_rdata",  last_rsp_rdata, 32'hDEAD_BEEF);

      // slave error on a read
      slv_waits = 0; slv_err = 1; slv_rdata = 32'h5A5A_1234;
      q1.push_back('{1'b0, 32'h40, 32'h0});
      wait_rsp(1, 20, "t6_rsp");
      chk("t6_slverr", last_rsp_err, 1);
      chk("t6_rdata",  last_rsp_rdata, 32'h5A5A_1234);
      slv_err = 0;

      // reset in the middle of a hung ACCESS
      slv_waits = -1;
      q1.push_back('{1'b0, 32'h50, 32'h0});
      k = 0;
      while (!(psel && penable) && k < 10) begin tick(); k++; end
      chk("t7_in_access", psel && penable, 1);
      repeat (3) tick();
      c0 = rsp_cnt[0]; c1 = rsp_cnt[1];
      #2;
      preset_n = 1'b0;
      #1;
      chk("t7_psel",    psel, 0);
      chk("t7_penable", penable, 0);
      chk("t7_busy",    busy, 0);
      chk("t7_paddr",   paddr, 0);
      chk("t7_rdata",   rsp_rdata, 0);
      chk("t7_slverr",  rsp_slverr, 0);
      chk("t7_rsp",     {rsp0_valid, rsp1_valid}, 0);
      repeat (2) tick();
      preset_n = 1'b1;
      repeat (20) tick();
      chk("t7_no_rsp0", rsp_cnt[0], c0);
      chk("t7_no_rsp1", rsp_cnt[1], c1);

      // first contention after reset goes to port 0
      slv_waits = 0;
      g0 = dut_grants.size();
      q0.push_back('{1'b0, 32'h60, 32'h0});
      q1.push_back('{1'b1, 32'h64, 32'h7777_0000});
      wait_both(c0 + 1, c1 + 1, 30, "t8");
      chk("t8_ngrants", dut_grants.size(), g0 + 2);
      if (dut_grants.size() >= g0 + 2) begin
         chk("t8_first", dut_grants[g0], 0);
         chk("t8_second", dut_grants[g0 + 1], 1);
      end

      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
